// File: rtl/phy_pkg.sv
// Shared PHY receive-path definitions: lane-order encoding and width helper.
package phy_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned clog2_p1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n; v != 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/phy_word_packer.sv
// Serial-to-parallel lane packer with ready/valid on both sides, flush of
// partial words with lane count, and optional discard of partial words on gaps.
module phy_word_packer
  import phy_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int RATIO       = 4,
  parameter int MSB_FIRST   = 1,
  parameter int DROP_ON_GAP = 0,
  localparam int OUT_W      = IN_W * RATIO,
  localparam int CW         = clog2_p1(RATIO)
) (
  input  logic             clk_4f_c,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CW-1:0]    out_lanes,
  output logic             drop_err
);

  if (RATIO < 2 || IN_W < 1) begin : g_param_check
    $error("phy_word_packer: RATIO must be >= 2 and IN_W >= 1");
  end

  localparam lane_order_e ORDER = (MSB_FIRST != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] pack;
  logic             pend;

  logic             can_load;
  logic             flush_req;
  logic             last_slot;
  logic             accept;
  logic             complete;
  logic             emit;
  logic             gap_drop;
  logic [CW-1:0]    fill;
  logic [OUT_W-1:0] merged;

  assign can_load  = !out_valid || out_ready;
  // A flush that met a full output is remembered until it can be emitted.
  assign flush_req = flush || pend;
  assign last_slot = (cnt == CW'(RATIO - 1));
  assign in_ready  = can_load || (!last_slot && !flush_req);
  assign accept    = in_valid && in_ready;
  assign fill      = cnt + CW'(accept);
  assign complete  = accept && last_slot;
  assign emit      = complete || (flush_req && can_load && (fill != '0));
  assign gap_drop  = (DROP_ON_GAP != 0) && !in_valid && (cnt != '0) && !flush_req;

  always_comb begin
    merged = pack;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (accept && (cnt == CW'(i))) begin
        if (ORDER == LANE_MSB_FIRST)
          merged[(RATIO - 1 - i) * IN_W +: IN_W] = in_data;
        else
          merged[i * IN_W +: IN_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk_4f_c) begin
    if (!reset) begin
      cnt       <= '0;
      pack      <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
      drop_err  <= 1'b0;
    end else begin
      drop_err <= (in_valid && !in_ready) || gap_drop;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= merged;
        out_lanes <= fill;
        cnt       <= '0;
        pack      <= '0;
        pend      <= 1'b0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (gap_drop) begin
          cnt  <= '0;
          pack <= '0;
        end else begin
          cnt  <= fill;
          pack <= merged;
        end
        pend <= flush_req && !can_load && (fill != '0);
      end
    end
  end

endmodule

// File: tb/tb_phy_word_packer.sv
// Bench for phy_word_packer: three configurations driven in lockstep and
// compared against a lane-list reference model, plus directed scenarios.
module tb_phy_word_packer;

  logic       clk_4f_c = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       flush;
  logic       out_ready;

  logic        rdy [3];
  logic        ov  [3];
  logic [31:0] od  [3];
  logic [2:0]  ol  [3];
  logic        de  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_4f_c = ~clk_4f_c;

  phy_word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .DROP_ON_GAP(0)) u_msb (
    .clk_4f_c(clk_4f_c), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_lanes(ol[0]), .drop_err(de[0]));

  phy_word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .DROP_ON_GAP(0)) u_lsb (
    .clk_4f_c(clk_4f_c), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_lanes(ol[1]), .drop_err(de[1]));

  phy_word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .DROP_ON_GAP(1)) u_gap (
    .clk_4f_c(clk_4f_c), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_lanes(ol[2]), .drop_err(de[2]));

  // Reference model: per configuration, a list of collected lanes plus the output slot.
  bit          m_msb [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_gap [3] = '{1'b0, 1'b0, 1'b1};
  int          m_cnt [3];
  logic [7:0]  m_lane[3][4];
  logic        m_pend[3];
  logic        m_ov  [3];
  logic [31:0] m_od  [3];
  int          m_ol  [3];
  logic        m_de  [3];
  logic        last_rdy0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] assemble(input int k, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      if (m_msb[k]) w = w | ({24'h0, m_lane[k][i]} << (8 * (3 - i)));
      else          w = w | ({24'h0, m_lane[k][i]} << (8 * i));
    end
    return w;
  endfunction

  function automatic logic model_rdy(input int k);
    logic can_load;
    can_load = !m_ov[k] || out_ready;
    return can_load || (m_cnt[k] != 3 && !(flush || m_pend[k]));
  endfunction

  task automatic model_step(input int k);
    logic can_load, freq, r, acc, emit, drop;
    int n;
    if (!reset) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_ov[k] = 0; m_od[k] = 0; m_ol[k] = 0; m_de[k] = 0;
      for (int i = 0; i < 4; i++) m_lane[k][i] = '0;
      return;
    end
    can_load = !m_ov[k] || out_ready;
    freq     = flush || m_pend[k];
    r        = model_rdy(k);
    acc      = in_valid && r;
    drop     = in_valid && !r;
    n        = m_cnt[k];
    if (acc) begin
      m_lane[k][n] = in_data;
      n++;
    end
    emit = (n == 4) || (freq && can_load && n != 0);
    if (emit) begin
      m_ov[k] = 1'b1;
      m_od[k] = assemble(k, n);
      m_ol[k] = n;
      m_cnt[k] = 0;
      m_pend[k] = 1'b0;
    end else begin
      if (out_ready) m_ov[k] = 1'b0;
      m_pend[k] = freq && !can_load && n != 0;
      if (m_gap[k] && !in_valid && m_cnt[k] != 0 && !freq) begin
        n = 0;
        drop = 1'b1;
      end
      m_cnt[k] = n;
    end
    if (m_cnt[k] == 0)
      for (int i = 0; i < 4; i++) m_lane[k][i] = '0;
    m_de[k] = drop;
  endtask

  task automatic cycle(input logic rst, input logic iv, input logic [7:0] d,
                       input logic fl, input logic ordy);
    reset = rst; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    #1;
    last_rdy0 = rdy[0];
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("in_ready[%0d]", k), {31'h0, rdy[k]}, {31'h0, model_rdy(k)});
      model_step(k);
    end
    @(posedge clk_4f_c);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("out_valid[%0d]", k), {31'h0, ov[k]}, {31'h0, m_ov[k]});
      check_eq($sformatf("out_data[%0d]", k), od[k], m_od[k]);
      check_eq($sformatf("out_lanes[%0d]", k), {29'h0, ol[k]}, 32'(m_ol[k]));
      check_eq($sformatf("drop_err[%0d]", k), {31'h0, de[k]}, {31'h0, m_de[k]});
    end
  endtask

  initial begin
    logic [7:0] lanes_a [4];
    lanes_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk_4f_c); #1;

    cycle(0, 0, 8'h00, 0, 1);
    cycle(0, 0, 8'h00, 0, 1);
    check_eq("rst_out_valid", {31'h0, ov[0]}, 32'h0);
    check_eq("rst_out_data", od[0], 32'h0);

    // Back-to-back word, both lane orders
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, lanes_a[i], 0, 1);
      if (i == 2) check_eq("early_valid", {31'h0, ov[0]}, 32'h0);
    end
    check_eq("word_msb", od[0], 32'hA1B2C3D4);
    check_eq("word_lsb", od[1], 32'hD4C3B2A1);
    check_eq("word_lanes", {29'h0, ol[0]}, 32'd4);
    check_eq("word_valid", {31'h0, ov[0]}, 32'h1);
    cycle(1, 0, 8'h00, 0, 1);
    check_eq("valid_one_cycle", {31'h0, ov[0]}, 32'h0);

    // Flush of a 2-lane partial, then a fresh word from lane 0
    cycle(1, 1, 8'h11, 0, 1);
    cycle(1, 1, 8'h22, 0, 1);
    cycle(1, 0, 8'h00, 1, 1);
    check_eq("flush_data", od[0], 32'h11220000);
    check_eq("flush_lanes", {29'h0, ol[0]}, 32'd2);
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h31 + i), 0, 1);
    check_eq("after_flush", od[0], 32'h31323334);

    // Gap: discarded on u_gap, merged on the others
    cycle(1, 1, 8'h01, 0, 1);
    cycle(1, 1, 8'h02, 0, 1);
    cycle(1, 0, 8'h00, 0, 1);
    check_eq("gap_drop_err", {31'h0, de[2]}, 32'h1);
    check_eq("gap_no_err_hold", {31'h0, de[0]}, 32'h0);
    cycle(1, 1, 8'h0A, 0, 1);
    cycle(1, 1, 8'h0B, 0, 1);
    check_eq("gap_merge_msb", od[0], 32'h01020A0B);
    check_eq("gap_merge_lsb", od[1], 32'h0B0A0201);
    cycle(1, 1, 8'h0C, 0, 1);
    cycle(1, 1, 8'h0D, 0, 1);
    check_eq("gap_clean_word", od[2], 32'h0A0B0C0D);
    cycle(1, 0, 8'h00, 1, 1);
    cycle(1, 0, 8'h00, 0, 1);

    // Backpressure: 8 lanes with the consumer stalled
    for (int i = 0; i < 7; i++) cycle(1, 1, 8'(8'h40 + i), 0, 0);
    check_eq("bp_hold", od[0], 32'h40414243);
    cycle(1, 1, 8'h47, 0, 0);
    check_eq("bp_in_ready", {31'h0, last_rdy0}, 32'h0);
    check_eq("bp_drop_err", {31'h0, de[0]}, 32'h1);
    cycle(1, 1, 8'h47, 0, 1);
    check_eq("bp_second", od[0], 32'h44454647);
    cycle(1, 0, 8'h00, 0, 1);

    // Reset mid-word with a word pending at the output
    for (int i = 0; i < 7; i++) cycle(1, 1, 8'(8'h50 + i), 0, 0);
    cycle(0, 1, 8'h57, 1, 0);
    check_eq("mid_rst_valid", {31'h0, ov[0]}, 32'h0);
    check_eq("mid_rst_data", od[0], 32'h0);
    check_eq("mid_rst_lanes", {29'h0, ol[0]}, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h60 + i), 0, 1);
    check_eq("post_rst_word", od[0], 32'h60616263);
    check_eq("post_rst_lanes", {29'h0, ol[0]}, 32'd4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
